// File: rtl/instr_fetch_unit_if.sv
// Instruction-fetch bus bundle: ROM address/data plus the pipeline control and IR signals.
// The fetch_count signal exists only when IFU_PERF_COUNT_EN is defined.
interface instr_fetch_unit_if;
  logic [15:0] pc_addr;
  logic [15:0] instr_in;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        resume;
  logic [15:0] ir_out;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        halted;
`ifdef IFU_PERF_COUNT_EN
  logic [15:0] fetch_count;
`endif

  // Fetch unit side.
  modport master (
    output pc_addr, ir_out, ir_pc, ir_valid, halted,
`ifdef IFU_PERF_COUNT_EN
    output fetch_count,
`endif
    input  instr_in, stall, branch_taken, branch_target, resume
  );

  // ROM / decode / execute side.
  modport slave (
    input  pc_addr, ir_out, ir_pc, ir_valid, halted,
`ifdef IFU_PERF_COUNT_EN
    input  fetch_count,
`endif
    output instr_in, stall, branch_taken, branch_target, resume
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, ROM addressing, IR with valid flag, branch flush, halt/resume.
// Optional saturating fetch counter enabled by defining IFU_PERF_COUNT_EN.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;

  always_comb begin
    // NOTE: every variable gets a hold default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;

    unique case (state_q)
      ST_BOOT: begin
        ir_valid_d = 1'b0;
        state_d    = ST_FETCH;
      end

      ST_FETCH: begin
        if (bus.branch_taken) begin
          // The word fetched this cycle is from the wrong path; drop it.
          pc_d       = bus.branch_target;
          ir_valid_d = 1'b0;
        end else if (!bus.stall) begin
          ir_d       = bus.instr_in;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          if (bus.instr_in == HALT_WORD) state_d = ST_HALTED;
          else                           pc_d    = pc_q + 16'd1;
        end
      end

      ST_HALTED: begin
        if (!bus.stall) ir_valid_d = 1'b0;
        if (bus.resume) begin
          pc_d    = pc_q + 16'd1;
          state_d = ST_FETCH;
        end
      end

      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      ir_q       <= 16'h0000;
      ir_pc_q    <= 16'h0000;
      ir_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign bus.pc_addr  = pc_q;
  assign bus.ir_out   = ir_q;
  assign bus.ir_pc    = ir_pc_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.halted   = (state_q == ST_HALTED);

`ifdef IFU_PERF_COUNT_EN
  logic        new_fetch;
  logic [15:0] fetch_count_q, fetch_count_d;

  always_comb begin
    new_fetch     = (state_q == ST_FETCH) && !bus.branch_taken && !bus.stall;
    fetch_count_d = fetch_count_q;
    if (new_fetch && (fetch_count_q != 16'hFFFF)) fetch_count_d = fetch_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) fetch_count_q <= 16'h0000;
    else     fetch_count_q <= fetch_count_d;
  end

  assign bus.fetch_count = fetch_count_q;
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the 16-bit Harvard core. Consumer end of the instruction-memory interface.
- Owns the program counter and drives the ROM address bus. Captures the 16-bit instruction word returned combinationally by the instruction ROM in the same cycle.
- Presents it to decode through an instruction register (IR) with a valid flag.
- Handles sequential fetch, stall, branch redirect with flush, and halt/resume.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_WORD, 16'hFFFF, instruction encoding that halts fetch.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_addr  output  16  address to instruction ROM; equals the PC register.
- instr_in  input  16  instruction word from ROM for pc_addr, valid in the same cycle.
- stall  input  1  decode/execute back-pressure; hold IR and PC.
- branch_taken  input  1  redirect request from execute, one-cycle pulse.
- branch_target  input  16  new PC when branch_taken=1.
- resume  input  1  leave HALTED, one-cycle pulse.
- ir_out  output  16  instruction register to decode.
- ir_pc  output  16  address ir_out was fetched from.
- ir_valid  output  1  ir_out holds a live instruction.
- halted  output  1  high while in HALTED.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - pc_addr=RESET_PC.
  - ir_out=0, ir_pc=0, ir_valid=0, halted=0.
  - state=BOOT.
  - rst overrides all other inputs in any state.
- State BOOT: one idle cycle. Hold PC, ir_valid=0. Next state FETCH unconditionally.
- State FETCH, per cycle, priority branch_taken > stall > normal.
  - branch_taken=1:
    - PC<=branch_target; ir_valid<=0 (flush the word fetched this cycle); ir_out/ir_pc hold.
    - Stall is ignored in that cycle.
    - If branch_target fetches HALT_WORD, it is handled on the next cycle like any word.
  - stall=1 (no branch): PC, ir_out, ir_pc, ir_valid all hold.
  - Normal, instr_in!=HALT_WORD: ir_out<=instr_in, ir_pc<=PC, ir_valid<=1, PC<=PC+1.
  - Normal, instr_in==HALT_WORD: ir_out<=instr_in, ir_pc<=PC, ir_valid<=1. PC holds (points at the halt word). Next state HALTED.
  - Fetch-to-IR latency is 1 cycle. Throughput is 1 instruction/cycle when unstalled.
- State HALTED:
  - halted=1.
  - ir_valid<=0 at the first edge in HALTED, so the halt word is presented for exactly one cycle unless stall holds it.
  - While stall=1, IR holds as in FETCH.
  - PC holds. branch_taken is ignored.
  - resume=1: PC<=PC+1; halted<=0 on the same edge; next state FETCH.
  - resume and stall together: resume wins for PC and state; IR holds.
- PC arithmetic: 16-bit unsigned, wraps 16'hFFFF -> 16'h0000 without flag.
- No combinational path from instr_in to any output. pc_addr is purely registered.

Optional Feature:
- Macro: IFU_PERF_COUNT_EN.
- With the macro defined:
  - Extra output fetch_count [15:0], reset to 0.
  - Increments on every edge where ir_valid is written to 1 from a new fetch. Stalls, flushes and HALTED do not count.
  - Saturates at 16'hFFFF.
- Without it: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: assert rst 2 cycles, ROM returns {A0,A1,A2} at 0..2.
  - Response: pc_addr=0 during BOOT; then ir_out=A0/ir_pc=0, A1/1, A2/2 on consecutive cycles with ir_valid=1.
- Stall hold:
  - Stimulus: stall=1 for 3 cycles after A1 is in IR.
  - Response: ir_out=A1, ir_pc=1, pc_addr=2 constant; A2 appears the cycle after stall drops.
- Branch flush:
  - Stimulus: branch_taken=1, branch_target=16'h0040 while pc_addr=5, with stall=1 simultaneously.
  - Response: next cycle pc_addr=0x40, ir_valid=0; following cycle ir_pc=0x40, ir_valid=1.
- Halt and resume:
  - Stimulus: ROM word at 3 is 16'hFFFF.
  - Response: ir_out=FFFF/ir_pc=3 valid one cycle; halted=1; pc_addr stays 3; ir_valid=0.
  - Stimulus: resume pulse.
  - Response: pc_addr=4, halted=0, fetch continues.
- Wrap and mid-operation reset:
  - Stimulus: branch to 16'hFFFF with a non-halt word there.
  - Response: next PC=0.
  - Stimulus: rst asserted while halted=1.
  - Response: state BOOT, pc_addr=RESET_PC, all outputs at reset values.
- Perf counter (IFU_PERF_COUNT_EN defined):
  - Stimulus: 4 fetches, 2 stall cycles, 1 branch flush, then halt.
  - Response: fetch_count increments per valid fetch including the halt word, unchanged during stall/flush/HALTED cycles.
